i2c_reg_sequencer: RTL and testbench

//  Command-level controller in front of the byte-level I2C `master`. Turns one register

---
 rtl/i2c_reg_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// Register read/write sequencer driving a byte-level I2C master.
// Optional NACK retry on address bytes: define I2C_SEQ_RETRY_EN.
module i2c_reg_sequencer #(
    parameter int BYTE_TIMEOUT = 100000,
    parameter int MAX_RETRIES  = 3
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_read,
    input  logic [6:0] cmd_dev_addr,
    input  logic [7:0] cmd_reg_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_status,
    output logic       busy,
    output logic       m_mode,
    output logic       m_transfer_start,
    output logic       m_transfer_continue,
    output logic [7:0] m_data_tx,
    input  logic       m_transfer_ready,
    input  logic       m_interrupt,
    input  logic       m_transaction_complete,
    input  logic       m_nack,
    input  logic       m_start_err,
    input  logic       m_arbitration_err,
    input  logic [7:0] m_data_rx
);

    typedef enum logic [3:0] {
        IDLE, WAIT_RDY, ADDR, REG, WDATA, GAP, RADDR, RDATA, RESP
    } state_t;

    localparam int TW = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST =
        (BYTE_TIMEOUT > 1) ? TW'(BYTE_TIMEOUT - 1) : '0;

    state_t          state;
    logic            rd_q;
    logic            phase2;
    logic [6:0]      dev_q;
    logic [7:0]      reg_q;
    logic [7:0]      wd_q;
    logic [TW-1:0]   tcnt;

    logic            in_byte;
    logic            addr_byte;
    logic            bus_err;
    logic            tx_nack;
    logic            timeout_hit;
    logic            retry_ok;
    logic            fin;
    logic            retry;
    logic [1:0]      fin_st;

    assign busy        = ~cmd_ready;
    assign in_byte     = state inside {ADDR, REG, WDATA, RADDR, RDATA};
    assign addr_byte   = (state == ADDR) || (state == RADDR);
    assign bus_err     = m_start_err | m_arbitration_err | ~m_transaction_complete;
    // the master NACKs the final received byte on purpose
    assign tx_nack     = m_nack && (state != RDATA);
    assign timeout_hit = (BYTE_TIMEOUT != 0) && (tcnt == T_LAST);

`ifdef I2C_SEQ_RETRY_EN
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    logic [RW-1:0] retry_cnt;
    assign retry_ok = addr_byte && (retry_cnt < RW'(MAX_RETRIES));
`else
    logic unused_max_retries;
    assign unused_max_retries = (MAX_RETRIES != 0) & addr_byte;
    assign retry_ok = 1'b0;
`endif

    always_comb begin
        fin    = 1'b0;
        retry  = 1'b0;
        fin_st = 2'd0;
        if (in_byte && m_interrupt) begin
            if (bus_err) begin
                fin    = 1'b1;
                fin_st = 2'd2;
            end else if (tx_nack) begin
                if (retry_ok) begin
                    retry = 1'b1;
                end else begin
                    fin    = 1'b1;
                    fin_st = 2'd1;
                end
            end else if (state == WDATA || state == RDATA) begin
                fin = 1'b1;
            end
        end else if (in_byte && timeout_hit) begin
            fin    = 1'b1;
            fin_st = 2'd3;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            cmd_ready           <= 1'b1;
            rsp_valid           <= 1'b0;
            rsp_rdata           <= 8'h00;
            rsp_status          <= 2'd0;
            m_mode              <= 1'b0;
            m_transfer_start    <= 1'b0;
            m_transfer_continue <= 1'b0;
            m_data_tx           <= 8'h00;
            rd_q                <= 1'b0;
            phase2              <= 1'b0;
            dev_q               <= 7'h00;
            reg_q               <= 8'h00;
            wd_q                <= 8'h00;
            tcnt                <= '0;
`ifdef I2C_SEQ_RETRY_EN
            retry_cnt           <= '0;
`endif
        end else if (fin) begin
            m_transfer_start    <= 1'b0;
            m_transfer_continue <= 1'b0;
            m_mode              <= 1'b0;
            tcnt                <= '0;
            rsp_valid           <= 1'b1;
            rsp_status          <= fin_st;
            rsp_rdata           <= (state == RDATA && fin_st == 2'd0)
                                   ? m_data_rx : 8'h00;
            state               <= RESP;
`ifdef I2C_SEQ_RETRY_EN
        end else if (retry) begin
            m_transfer_start    <= 1'b0;
            m_transfer_continue <= 1'b0;
            m_mode              <= 1'b0;
            tcnt                <= '0;
            retry_cnt           <= retry_cnt + 1'b1;
            state               <= WAIT_RDY;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rd_q      <= cmd_read;
                        dev_q     <= cmd_dev_addr;
                        reg_q     <= cmd_reg_addr;
                        wd_q      <= cmd_wdata;
                        phase2    <= 1'b0;
                        cmd_ready <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
                        retry_cnt <= '0;
`endif
                        state     <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (m_transfer_ready) begin
                        m_mode              <= 1'b0;
                        m_transfer_start    <= 1'b1;
                        m_transfer_continue <= 1'b0;
                        m_data_tx           <= {dev_q, phase2};
                        tcnt                <= '0;
                        state               <= phase2 ? RADDR : ADDR;
                    end
                end
                ADDR: begin
                    if (m_interrupt) begin
                        m_transfer_start    <= 1'b0;
                        m_transfer_continue <= 1'b1;
                        m_data_tx           <= reg_q;
                        tcnt                <= '0;
                        state               <= REG;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                REG: begin
                    if (m_interrupt) begin
                        tcnt <= '0;
                        if (rd_q) begin
                            m_transfer_continue <= 1'b0;
                            state               <= GAP;
                        end else begin
                            m_data_tx <= wd_q;
                            state     <= WDATA;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP: begin
                    phase2 <= 1'b1;
                    state  <= WAIT_RDY;
                end
                RADDR: begin
                    if (m_interrupt) begin
                        m_transfer_start    <= 1'b0;
                        m_transfer_continue <= 1'b1;
                        m_mode              <= 1'b1;
                        tcnt                <= '0;
                        state               <= RDATA;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WDATA, RDATA: begin
                    tcnt <= tcnt + 1'b1;
                end
                RESP: begin
                    rsp_valid  <= 1'b0;
                    rsp_rdata  <= 8'h00;
                    rsp_status <= 2'd0;
                    cmd_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: behavioural byte master, vector table, scoreboard.
// Retry expectations follow I2C_SEQ_RETRY_EN when it is defined for the bench too.
module tb_i2c_reg_sequencer;

    logic       clk_in;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_read;
    logic [6:0] cmd_dev_addr;
    logic [7:0] cmd_reg_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_status;
    logic       busy;
    logic       m_mode;
    logic       m_transfer_start;
    logic       m_transfer_continue;
    logic [7:0] m_data_tx;
    logic       m_transfer_ready;
    logic       m_interrupt;
    logic       m_transaction_complete;
    logic       m_nack;
    logic       m_start_err;
    logic       m_arbitration_err;
    logic [7:0] m_data_rx;

    i2c_reg_sequencer #(.BYTE_TIMEOUT(50), .MAX_RETRIES(3)) dut (
        .clk_in(clk_in), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status), .busy(busy), .m_mode(m_mode),
        .m_transfer_start(m_transfer_start),
        .m_transfer_continue(m_transfer_continue), .m_data_tx(m_data_tx),
        .m_transfer_ready(m_transfer_ready), .m_interrupt(m_interrupt),
        .m_transaction_complete(m_transaction_complete), .m_nack(m_nack),
        .m_start_err(m_start_err), .m_arbitration_err(m_arbitration_err),
        .m_data_rx(m_data_rx)
    );

`ifdef I2C_SEQ_RETRY_EN
    localparam int NTRY = 4;
`else
    localparam int NTRY = 1;
`endif

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;
    int rsp_cnt = 0;
    int start_hi = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural byte master ----------------
    typedef struct packed {
        logic [7:0] data;
        logic       st;
        logic       co;
        logic       md;
    } byte_t;

    byte_t      blog[$];
    logic       mdl_int;
    logic       stray_int;
    logic       mdl_busy;
    int         cnt;
    int         lat = 3;
    bit         hold = 0;
    bit         nack_en = 0;
    logic [7:0] nack_val = 8'h00;
    bit         nack_rx = 0;
    int         err_at = -1;
    int         err_kind = 0;
    int         nack_addr_cnt = 0;
    byte_t      cur;
    bit         is_err;
    bit         nk;

    assign m_interrupt = mdl_int | stray_int;

    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            mdl_int <= 1'b0;
            mdl_busy <= 1'b0;
            cnt <= 0;
            m_nack <= 1'b0;
            m_start_err <= 1'b0;
            m_arbitration_err <= 1'b0;
            m_transaction_complete <= 1'b0;
        end else begin
            mdl_int <= 1'b0;
            m_nack <= 1'b0;
            m_start_err <= 1'b0;
            m_arbitration_err <= 1'b0;
            m_transaction_complete <= 1'b0;
            if (!(m_transfer_start || m_transfer_continue)) begin
                mdl_busy <= 1'b0;
            end else if (!m_interrupt) begin
                if (!mdl_busy) begin
                    mdl_busy <= 1'b1;
                    cnt <= 0;
                    blog.push_back({m_data_tx, m_transfer_start,
                                    m_transfer_continue, m_mode});
                end else if (!hold && cnt == lat) begin
                    cur = blog[blog.size() - 1];
                    is_err = (blog.size() - 1) == err_at;
                    nk = (nack_en && cur.data == nack_val && !cur.md)
                       || (nack_rx && cur.md)
                       || (cur.st && nack_addr_cnt > 0);
                    if (cur.st && nack_addr_cnt > 0) nack_addr_cnt--;
                    mdl_int <= 1'b1;
                    mdl_busy <= 1'b0;
                    m_nack <= nk;
                    m_start_err <= is_err && err_kind == 2;
                    m_arbitration_err <= is_err && err_kind == 1;
                    m_transaction_complete <= !is_err;
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0] st;
        logic [7:0] rd;
    } rsp_t;

    rsp_t sb[$];
    rsp_t e;

    always @(negedge clk_in) begin
        if (m_transfer_start) start_hi++;
        if (!reset && rsp_valid) begin
            rsp_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: status %0d with nothing pending",
                         rsp_status);
            end else begin
                e = sb.pop_front();
                chk("rsp_status", rsp_status, e.st);
                chk("rsp_rdata", rsp_rdata, e.rd);
            end
        end
    end

    task automatic run_cmd(input bit rd, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd,
                           input logic [1:0] st, input logic [7:0] rdat,
                           input bit spam);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        blog.delete();
        start_hi = 0;
        cmd_read = rd;
        cmd_dev_addr = dev;
        cmd_reg_addr = rg;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        sb.push_back({st, rdat});
        @(negedge clk_in);
        chk("busy_after_accept", busy, 1);
        if (spam) begin
            cmd_dev_addr = 7'h11;
            cmd_reg_addr = 8'h99;
            cmd_wdata = 8'h77;
        end else begin
            cmd_valid = 1'b0;
        end
        n = 0;
        while ((sb.size() != 0 || !cmd_ready) && n < 3000) begin
            @(negedge clk_in);
            n++;
            if (spam && n == 10) begin
                chk("ready_low_while_busy", cmd_ready, 0);
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL cmd_wait: got no response within %0d cycles, required one", n);
            sb.delete();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         rd;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic [7:0] rx;
        bit         nk_en;
        logic [7:0] nk_val;
        bit         nk_rx;
        int         e_at;
        int         e_kind;
        logic [1:0] st;
        logic [7:0] rdat;
        int         cnt;
        logic [63:0] bytes;
        logic [7:0] smask;
        logic [7:0] mmask;
    } vec_t;

    vec_t vt[10];
    int   base;

    initial begin
        vt[0] = '{0, 7'h50, 8'h12, 8'hA5, 8'h00, 0, 8'h00, 0, -1, 0,
                  2'd0, 8'h00, 3, 64'hA512A0, 8'b0001, 8'b0000};
        vt[1] = '{1, 7'h50, 8'h07, 8'h00, 8'hB4, 0, 8'h00, 0, -1, 0,
                  2'd0, 8'hB4, 4, 64'h00A107A0, 8'b0101, 8'b1000};
        vt[2] = '{0, 7'h50, 8'h12, 8'hA5, 8'h00, 1, 8'hA0, 0, -1, 0,
                  2'd1, 8'h00, NTRY, 64'hA0A0A0A0A0A0A0A0, 8'hFF, 8'h00};
        vt[3] = '{0, 7'h50, 8'h34, 8'h5A, 8'h00, 0, 8'h00, 0, 1, 1,
                  2'd2, 8'h00, 2, 64'h34A0, 8'b0001, 8'b0000};
        vt[4] = '{1, 7'h50, 8'h07, 8'h00, 8'h66, 0, 8'h00, 0, 1, 2,
                  2'd2, 8'h00, 2, 64'h07A0, 8'b0001, 8'b0000};
        vt[5] = '{0, 7'h00, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, -1, 0,
                  2'd0, 8'h00, 3, 64'h00FF00, 8'b0001, 8'b0000};
        vt[6] = '{1, 7'h7F, 8'h80, 8'h00, 8'h3C, 0, 8'h00, 1, -1, 0,
                  2'd0, 8'h3C, 4, 64'h00FF80FE, 8'b0101, 8'b1000};
        vt[7] = '{0, 7'h50, 8'h12, 8'h5A, 8'h00, 1, 8'h5A, 0, -1, 0,
                  2'd1, 8'h00, 3, 64'h5A12A0, 8'b0001, 8'b0000};
        vt[8] = '{1, 7'h50, 8'h07, 8'h00, 8'h55, 1, 8'hA1, 0, -1, 0,
                  2'd1, 8'h00, 2 + NTRY, 64'hA1A1A1A1A1A107A0,
                  8'b11111101, 8'b0000};
        vt[9] = '{1, 7'h50, 8'h07, 8'h00, 8'h99, 0, 8'h00, 0, 3, 3,
                  2'd2, 8'h00, 4, 64'h00A107A0, 8'b0101, 8'b1000};

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_read = 1'b0;
        cmd_dev_addr = 7'h00;
        cmd_reg_addr = 8'h00;
        cmd_wdata = 8'h00;
        m_transfer_ready = 1'b1;
        m_data_rx = 8'h00;
        stray_int = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset strobes", {m_transfer_start, m_transfer_continue, m_mode}, 0);
        chk("reset data_tx", m_data_tx, 0);
        chk("reset rsp", {rsp_status, rsp_rdata}, 0);
        reset = 1'b0;
        @(negedge clk_in);

        for (int i = 0; i < 10; i++) begin
            nack_en = vt[i].nk_en;
            nack_val = vt[i].nk_val;
            nack_rx = vt[i].nk_rx;
            err_at = vt[i].e_at;
            err_kind = vt[i].e_kind;
            m_data_rx = vt[i].rx;
            run_cmd(vt[i].rd, vt[i].dev, vt[i].rg, vt[i].wd,
                    vt[i].st, vt[i].rdat, 0);
            chk($sformatf("v%0d byte_count", i), blog.size(), vt[i].cnt);
            for (int j = 0; j < blog.size() && j < vt[i].cnt && j < 8; j++) begin
                chk($sformatf("v%0d b%0d start", i, j), blog[j].st, vt[i].smask[j]);
                chk($sformatf("v%0d b%0d cont", i, j), blog[j].co, !vt[i].smask[j]);
                chk($sformatf("v%0d b%0d mode", i, j), blog[j].md, vt[i].mmask[j]);
                if (!vt[i].mmask[j])
                    chk($sformatf("v%0d b%0d data", i, j), blog[j].data,
                        vt[i].bytes[8*j +: 8]);
            end
        end
        nack_en = 0;
        nack_rx = 0;
        err_at = -1;

        // address NACKed twice: retried to success, or reported at once
        nack_addr_cnt = 2;
`ifdef I2C_SEQ_RETRY_EN
        run_cmd(0, 7'h50, 8'h12, 8'hA5, 2'd0, 8'h00, 0);
        chk("retry byte_count", blog.size(), 5);
        base = 0;
        foreach (blog[k]) if (blog[k].st) base++;
        chk("retry starts", base, 3);
`else
        run_cmd(0, 7'h50, 8'h12, 8'hA5, 2'd1, 8'h00, 0);
        chk("nack byte_count", blog.size(), 1);
`endif
        nack_addr_cnt = 0;

        // withheld interrupt: start strobe held exactly BYTE_TIMEOUT cycles
        hold = 1;
        run_cmd(0, 7'h50, 8'h12, 8'hA5, 2'd3, 8'h00, 0);
        chk("timeout strobe_cycles", start_hi, 50);
        chk("timeout byte_count", blog.size(), 1);
        hold = 0;

        // interrupt lands on the timeout cycle: interrupt wins
        lat = 47;
        run_cmd(0, 7'h50, 8'h12, 8'hA5, 2'd0, 8'h00, 0);
        chk("tie byte_count", blog.size(), 3);
        lat = 48;
        run_cmd(0, 7'h50, 8'h12, 8'hA5, 2'd3, 8'h00, 0);
        chk("late byte_count", blog.size(), 1);
        lat = 3;

        // commands offered while busy are dropped
        run_cmd(0, 7'h50, 8'h12, 8'hA5, 2'd0, 8'h00, 1);
        chk("spam byte_count", blog.size(), 3);
        if (blog.size() > 1) chk("spam reg byte", blog[1].data, 8'h12);

        // stray interrupt while idle
        base = rsp_cnt;
        stray_int = 1'b1;
        @(negedge clk_in);
        stray_int = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("stray cmd_ready", cmd_ready, 1);
        chk("stray strobes", {m_transfer_start, m_transfer_continue}, 0);
        chk("stray rsp", rsp_cnt, base);

        // reset in the middle of a read
        blog.delete();
        m_data_rx = 8'h42;
        cmd_read = 1'b1;
        cmd_dev_addr = 7'h50;
        cmd_reg_addr = 8'h07;
        cmd_valid = 1'b1;
        @(negedge clk_in);
        cmd_valid = 1'b0;
        base = 0;
        while (blog.size() < 3 && base < 500) begin
            @(negedge clk_in);
            base++;
        end
        chk("midread reached raddr", blog.size() >= 3, 1);
        base = rsp_cnt;
        #2 reset = 1'b1;
        #1;
        chk("midread strobes", {m_transfer_start, m_transfer_continue}, 0);
        chk("midread cmd_ready", cmd_ready, 1);
        chk("midread busy", busy, 0);
        @(negedge clk_in);
        reset = 1'b0;
        repeat (30) @(negedge clk_in);
        chk("midread no rsp", rsp_cnt, base);
        chk("midread idle", {cmd_ready, m_transfer_start}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
